exhaustive_stim_gen: RTL

Synthesizable, parametrised exhaustive stimulus sequencer for combinational or registered DUTs. It drives every input vector 0..2^IN_W-1 in order and holds each vector for a programmable settle time. It then samples the DUT response and folds each sample into a MISR signature, exposing a per-vector capture strobe for logging. It sits between a bench or on-chip controller (start/abort/done handshake) and the DUT under test, and replaces hand-written for-loop stimulus with a reusable block.

---
 rtl/exhaustive_stim_gen.sv | 121 ++++++++++++
 1 files changed

// File: rtl/exhaustive_stim_gen.sv
// Exhaustive stimulus sequencer: walks every IN_W-bit vector, holds it for
// SETTLE_CYCLES, then captures the DUT response and folds it into a MISR.
module exhaustive_stim_gen #(
    parameter int IN_W          = 3,
    parameter int OUT_W         = 1,
    parameter int SETTLE_CYCLES = 4,
    parameter int SIG_W         = 16,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] SEED = SIG_W'(16'hFFFF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic             sample_valid,
    output logic [IN_W-1:0]  cap_idx,
    output logic [OUT_W-1:0] resp_q,
    output logic [SIG_W-1:0] signature
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [IN_W-1:0] STIM_LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  stim_q, stim_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sample_valid_q, sample_valid_d;
    logic [IN_W-1:0]  cap_idx_q, cap_idx_d;
    logic [OUT_W-1:0] resp_q_q, resp_q_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [SIG_W-1:0] misr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            stim_q         <= '0;
            cnt_q          <= '0;
            sample_valid_q <= 1'b0;
            cap_idx_q      <= '0;
            resp_q_q       <= '0;
            sig_q          <= '0;
        end else begin
            state_q        <= state_d;
            stim_q         <= stim_d;
            cnt_q          <= cnt_d;
            sample_valid_q <= sample_valid_d;
            cap_idx_q      <= cap_idx_d;
            resp_q_q       <= resp_q_d;
            sig_q          <= sig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) state_d = S_SETTLE;
                S_SETTLE:       if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
                S_SAMPLE:       state_d = (stim_q == STIM_LAST) ? S_DONE : S_SETTLE;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    assign misr_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)
                     ^ SIG_W'(resp);

    // Abort keeps signature/capture registers so a halted sweep can be inspected.
    always_comb begin
        stim_d         = stim_q;
        cnt_d          = cnt_q;
        sample_valid_d = 1'b0;
        cap_idx_d      = cap_idx_q;
        resp_q_d       = resp_q_q;
        sig_d          = sig_q;
        if (abort) begin
            stim_d = '0;
            cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        stim_d = '0;
                        cnt_d  = '0;
                        sig_d  = SEED;
                    end
                end
                S_SETTLE: cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
                S_SAMPLE: begin
                    resp_q_d       = resp;
                    cap_idx_d      = stim_q;
                    sample_valid_d = 1'b1;
                    sig_d          = misr_next;
                    if (stim_q != STIM_LAST) stim_d = stim_q + IN_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
        done = (state_q == S_DONE);
    end

    assign stim         = stim_q;
    assign sample_valid = sample_valid_q;
    assign cap_idx      = cap_idx_q;
    assign resp_q       = resp_q_q;
    assign signature    = sig_q;

endmodule
